// File: rtl/alu_int_divider.sv
// Iterative signed divider for the Execution stage: restoring shift-subtract,
// one quotient bit per clock, with saturation and divide-by-zero handling.
module alu_int_divider #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] B,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] Q,
   output logic [DATA_WIDTH-1:0] R,
   output logic                  N,
   output logic                  V,
   output logic                  Z,
   output logic                  DZ
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(W + 1);

   localparam logic [W-1:0] MAX_POS  = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] MAX_NEG  = {1'b1, {(W-1){1'b0}}};
   localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FINISH
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  dvd_q, dvd_d;       // dividend bits shift out, quotient bits shift in
   logic [W:0]    rem_q, rem_d;
   logic [W-1:0]  dvs_q, dvs_d;
   logic          neg_quo_q, neg_quo_d;
   logic          neg_rem_q, neg_rem_d;
   logic          sat_q, sat_d;
   logic          dzf_q, dzf_d;

   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [W-1:0]  q_out_q, q_out_d;
   logic [W-1:0]  r_out_q, r_out_d;
   logic          n_q, n_d;
   logic          v_q, v_d;
   logic          z_q, z_d;
   logic          dz_q, dz_d;

   logic [W-1:0]  a_mag;
   logic [W-1:0]  b_mag;
   logic [W:0]    rem_shift;
   logic [W+1:0]  trial;
   logic [W-1:0]  quo_fin;
   logic [W-1:0]  rem_fin;

   // Magnitudes are unsigned W-bit, so |max_neg| = 2^(W-1) is representable.
   assign a_mag = A[W-1] ? (~A + 1'b1) : A;
   assign b_mag = B[W-1] ? (~B + 1'b1) : B;

   assign rem_shift = {rem_q[W-1:0], dvd_q[W-1]};
   assign trial     = {1'b0, rem_shift} - {2'b00, dvs_q};

   assign quo_fin = neg_quo_q ? (~dvd_q + 1'b1) : dvd_q;
   assign rem_fin = neg_rem_q ? (~rem_q[W-1:0] + 1'b1) : rem_q[W-1:0];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dvd_d     = dvd_q;
      rem_d     = rem_q;
      dvs_d     = dvs_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      sat_d     = sat_q;
      dzf_d     = dzf_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      q_out_d   = q_out_q;
      r_out_d   = r_out_q;
      n_d       = n_q;
      v_d       = v_q;
      z_d       = z_q;
      dz_d      = dz_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               busy_d    = 1'b1;
               neg_quo_d = 1'b0;
               neg_rem_d = 1'b0;
               if (B == '0) begin
                  // Special cases stage final values unsigned so FINISH passes them through.
                  dvd_d   = A[W-1] ? MAX_NEG : MAX_POS;
                  rem_d   = {A[W-1], A};
                  sat_d   = 1'b1;
                  dzf_d   = 1'b1;
                  state_d = FINISH;
               end else if ((A == MAX_NEG) && (B == ALL_ONES)) begin
                  dvd_d   = MAX_POS;
                  rem_d   = '0;
                  sat_d   = 1'b1;
                  dzf_d   = 1'b0;
                  state_d = FINISH;
               end else begin
                  dvd_d     = a_mag;
                  dvs_d     = b_mag;
                  rem_d     = '0;
                  neg_quo_d = A[W-1] ^ B[W-1];
                  neg_rem_d = A[W-1];
                  sat_d     = 1'b0;
                  dzf_d     = 1'b0;
                  cnt_d     = CW'(W);
                  state_d   = CALC;
               end
            end
         end

         CALC: begin
            // A set top bit of the trial means it went negative: restore.
            if (trial[W+1]) begin
               rem_d = rem_shift;
            end else begin
               rem_d = trial[W:0];
            end
            dvd_d = {dvd_q[W-2:0], ~trial[W+1]};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               state_d = FINISH;
            end
         end

         FINISH: begin
            q_out_d = quo_fin;
            r_out_d = rem_fin;
            n_d     = quo_fin[W-1];
            z_d     = (quo_fin == '0);
            v_d     = sat_q;
            dz_d    = dzf_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         dvd_q     <= '0;
         rem_q     <= '0;
         dvs_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         sat_q     <= 1'b0;
         dzf_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         q_out_q   <= '0;
         r_out_q   <= '0;
         n_q       <= 1'b0;
         v_q       <= 1'b0;
         z_q       <= 1'b0;
         dz_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dvd_q     <= dvd_d;
         rem_q     <= rem_d;
         dvs_q     <= dvs_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         sat_q     <= sat_d;
         dzf_q     <= dzf_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         q_out_q   <= q_out_d;
         r_out_q   <= r_out_d;
         n_q       <= n_d;
         v_q       <= v_d;
         z_q       <= z_d;
         dz_q      <= dz_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign Q    = q_out_q;
   assign R    = r_out_q;
   assign N    = n_q;
   assign V    = v_q;
   assign Z    = z_q;
   assign DZ   = dz_q;

endmodule

// File: tb/tb_alu_int_divider.sv
// Scoreboard bench for alu_int_divider: directed vectors queue expectations,
// a monitor compares every done pulse against the queue head.
module tb_alu_int_divider;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] A;
   logic [15:0] B;
   logic        busy;
   logic        done;
   logic [15:0] Q;
   logic [15:0] R;
   logic        N;
   logic        V;
   logic        Z;
   logic        DZ;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] q;
      logic [15:0] r;
      logic        n;
      logic        v;
      logic        z;
      logic        dz;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_assert = 0;
   int   n_fail = 0;

   alu_int_divider #(.DATA_WIDTH(16)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start),
      .A    (A),
      .B    (B),
      .busy (busy),
      .done (done),
      .Q    (Q),
      .R    (R),
      .N    (N),
      .V    (V),
      .Z    (Z),
      .DZ   (DZ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            $display("txn A=%0d B=%0d -> Q=%0d R=%0d N=%0b V=%0b Z=%0b DZ=%0b lat=%0d",
                     $signed(e.a), $signed(e.b), $signed(Q), $signed(R), N, V, Z, DZ, cyc - e.acc);
            chk("Q", {16'h0, Q}, {16'h0, e.q});
            chk("R", {16'h0, R}, {16'h0, e.r});
            chk("N", {31'h0, N}, {31'h0, e.n});
            chk("V", {31'h0, V}, {31'h0, e.v});
            chk("Z", {31'h0, Z}, {31'h0, e.z});
            chk("DZ", {31'h0, DZ}, {31'h0, e.dz});
            chk("busy_at_done", {31'h0, busy}, 32'd0);
            chk("latency", 32'(cyc - e.acc), 32'(e.lat));
         end
      end
   end

   task automatic wait_idle();
      int k;
      k = 0;
      @(negedge clk);
      while (busy && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (busy) chk("idle_timeout", 32'd1, 32'd0);
   endtask

   task automatic issue(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] q, input logic [15:0] r,
                        input logic n, input logic v, input logic z, input logic dz,
                        input int lat, input bit push);
      exp_t e;
      wait_idle();
      A     = a;
      B     = b;
      start = 1'b1;
      if (push) begin
         e.a = a; e.b = b; e.q = q; e.r = r;
         e.n = n; e.v = v; e.z = z; e.dz = dz;
         e.lat = lat;
         e.acc = cyc + 1;
         sb.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
      A     = 16'hxxxx;
      B     = 16'hxxxx;
   endtask

   initial begin
      int k;
      rst_n = 1'b0;
      start = 1'b0;
      A     = '0;
      B     = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'h0, busy}, 32'd0);
      chk("rst_done", {31'h0, done}, 32'd0);
      chk("rst_Q", {16'h0, Q}, 32'd0);
      chk("rst_flags", {28'h0, N, V, Z, DZ}, 32'd0);
      rst_n = 1'b1;

      //     A        B        Q        R        N     V     Z     DZ    lat
      issue(16'd100,  16'd7,   16'd14,  16'd2,   1'b0, 1'b0, 1'b0, 1'b0, 17, 1);
      issue(-16'd100, 16'd7,   -16'd14, -16'd2,  1'b1, 1'b0, 1'b0, 1'b0, 17, 1);
      issue(16'd100,  -16'd7,  -16'd14, 16'd2,   1'b1, 1'b0, 1'b0, 1'b0, 17, 1);
      issue(-16'd100, -16'd7,  16'd14,  -16'd2,  1'b0, 1'b0, 1'b0, 1'b0, 17, 1);
      issue(16'h8000, 16'hFFFF,16'h7FFF,16'd0,   1'b0, 1'b1, 1'b0, 1'b0, 1,  1);
      issue(16'h8000, 16'd1,   16'h8000,16'd0,   1'b1, 1'b0, 1'b0, 1'b0, 17, 1);
      issue(16'd5,    16'd0,   16'h7FFF,16'd5,   1'b0, 1'b1, 1'b0, 1'b1, 1,  1);
      issue(-16'd5,   16'd0,   16'h8000,-16'd5,  1'b1, 1'b1, 1'b0, 1'b1, 1,  1);
      issue(16'd0,    16'd0,   16'h7FFF,16'd0,   1'b0, 1'b1, 1'b0, 1'b1, 1,  1);
      issue(16'd7,    -16'd2,  -16'd3,  16'd1,   1'b1, 1'b0, 1'b0, 1'b0, 17, 1);
      issue(16'h7FFF, 16'h7FFF,16'd1,   16'd0,   1'b0, 1'b0, 1'b0, 1'b0, 17, 1);
      issue(16'd3,    16'd7,   16'd0,   16'd3,   1'b0, 1'b0, 1'b1, 1'b0, 17, 1);

      // A start mid-busy is dropped and outputs keep the previous result.
      repeat (3) @(negedge clk);
      A     = 16'd50;
      B     = 16'd5;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_mid_calc", {31'h0, busy}, 32'd1);
      chk("Q_held_mid_calc", {16'h0, Q}, 32'd1);
      chk("R_held_mid_calc", {16'h0, R}, 32'd0);

      // Reset mid-CALC aborts with no done pulse.
      issue(16'd1000, 16'd3, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      repeat (7) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", {31'h0, busy}, 32'd0);
      chk("abort_done", {31'h0, done}, 32'd0);
      chk("abort_Q", {16'h0, Q}, 32'd0);
      chk("abort_R", {16'h0, R}, 32'd0);
      chk("abort_flags", {28'h0, N, V, Z, DZ}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      issue(16'd81, 16'd9, 16'd9, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 17, 1);

      k = 0;
      while (sb.size() != 0 && k < 100) begin
         @(negedge clk);
         k++;
      end
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
